// File: rtl/lsu_seq.sv
`default_nettype none
// ============================================================================
// Module   : lsu_seq
// Purpose  : Load/store sequencer. Accepts one memory request, checks
//            alignment, runs a single-beat pipelined Wishbone B4 cycle on a
//            64-bit bus, places store bytes on lanes, and aligns and extends
//            load data for writeback.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_i, reset_i         clock, asynchronous active-high reset
//   req_i .. rd_i          request from execute (sampled when busy_o=0)
//   busy_o                 pipeline stall while an access is in flight
//   done_o, rwe_o, rd_o    completion pulse, reg write enable, dest reg
//   rdat_o                 extended load result (held between loads)
//   misaligned_o, buserr_o fault flags, valid with done_o
//   wbm_*                  Wishbone B4 pipelined master port
// ============================================================================
module lsu_seq #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] dat_i,
  input  logic [4:0]  rd_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        rwe_o,
  output logic [4:0]  rd_o,
  output logic [63:0] rdat_o,
  output logic        misaligned_o,
  output logic        buserr_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [63:0] wbm_adr_o,
  output logic [7:0]  wbm_sel_o,
  output logic [63:0] wbm_dat_o,
  input  logic [63:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_stall_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  // Counter value at which the next bus cycle without a response aborts.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  to_cnt, to_cnt_nxt;
  logic        we_q, we_nxt;
  logic [1:0]  size_q, size_nxt;
  logic        uns_q, uns_nxt;
  logic [2:0]  off_q, off_nxt;

  logic        busy_nxt, done_nxt, rwe_nxt, mis_nxt, berr_nxt;
  logic        cyc_nxt, stb_nxt, bwe_nxt;
  logic [4:0]  rd_nxt;
  logic [63:0] rdat_nxt, adr_nxt, wdat_nxt;
  logic [7:0]  sel_nxt;

  // --------------------------------------------------------------------------
  // Request decode: lane mask and alignment check on the live request inputs
  // --------------------------------------------------------------------------
  logic        misaligned_in;
  logic [7:0]  lane_mask;
  logic [7:0]  sel_in;
  logic [63:0] store_lanes;

  always_comb begin
    lane_mask     = 8'h01;
    misaligned_in = 1'b0;
    unique case (size_i)
      2'd0: begin
        lane_mask     = 8'h01;
        misaligned_in = 1'b0;
      end
      2'd1: begin
        lane_mask     = 8'h03;
        misaligned_in = addr_i[0];
      end
      2'd2: begin
        lane_mask     = 8'h0F;
        misaligned_in = |addr_i[1:0];
      end
      default: begin
        lane_mask     = 8'hFF;
        misaligned_in = |addr_i[2:0];
      end
    endcase
  end

  // Only used for aligned requests, so the shifted mask never overflows.
  assign sel_in      = lane_mask << addr_i[2:0];
  assign store_lanes = dat_i << {addr_i[2:0], 3'b000};

  // --------------------------------------------------------------------------
  // Load data: shift the addressed lane down, then sign/zero extend
  // --------------------------------------------------------------------------
  logic [63:0] load_raw;
  logic [63:0] load_ext;

  assign load_raw = wbm_dat_i >> {off_q, 3'b000};

  always_comb begin
    load_ext = load_raw;
    unique case (size_q)
      2'd0:    load_ext = {{56{~uns_q & load_raw[7]}},  load_raw[7:0]};
      2'd1:    load_ext = {{48{~uns_q & load_raw[15]}}, load_raw[15:0]};
      2'd2:    load_ext = {{32{~uns_q & load_raw[31]}}, load_raw[31:0]};
      default: load_ext = load_raw;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic. Every output is registered, so this
  // block computes the value each output register takes at the next edge.
  // --------------------------------------------------------------------------
  logic resp_seen;

  always_comb begin
    state_nxt  = state;
    to_cnt_nxt = to_cnt;
    we_nxt     = we_q;
    size_nxt   = size_q;
    uns_nxt    = uns_q;
    off_nxt    = off_q;
    rd_nxt     = rd_o;
    rdat_nxt   = rdat_o;
    adr_nxt    = wbm_adr_o;
    sel_nxt    = wbm_sel_o;
    wdat_nxt   = wbm_dat_o;
    rwe_nxt    = 1'b0;
    mis_nxt    = 1'b0;
    berr_nxt   = 1'b0;
    // In REQ a response only counts once the request itself is taken.
    resp_seen  = (state == S_WAIT) || !wbm_stall_i;

    unique case (state)
      S_IDLE: begin
        if (req_i) begin
          we_nxt     = we_i;
          size_nxt   = size_i;
          uns_nxt    = unsigned_i;
          off_nxt    = addr_i[2:0];
          rd_nxt     = rd_i;
          to_cnt_nxt = 8'd0;
          if (misaligned_in) begin
            state_nxt = S_FIN;
            mis_nxt   = 1'b1;
          end else begin
            state_nxt = S_REQ;
            adr_nxt   = {addr_i[63:3], 3'b000};
            sel_nxt   = sel_in;
            wdat_nxt  = we_i ? store_lanes : 64'd0;
          end
        end
      end

      S_REQ, S_WAIT: begin
        if (resp_seen && wbm_err_i) begin
          // err wins over a simultaneous ack
          state_nxt = S_FIN;
          berr_nxt  = 1'b1;
        end else if (resp_seen && wbm_ack_i) begin
          state_nxt = S_FIN;
          if (!we_q) begin
            rwe_nxt  = 1'b1;
            rdat_nxt = load_ext;
          end
        end else if (to_cnt == TO_LAST) begin
          state_nxt = S_FIN;
          berr_nxt  = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + 8'd1;
          if (state == S_REQ && !wbm_stall_i) begin
            state_nxt = S_WAIT;
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // FIN always leaves after one cycle, so entering it marks completion.
    done_nxt = (state_nxt == S_FIN);
    busy_nxt = (state_nxt != S_IDLE);
    cyc_nxt  = (state_nxt == S_REQ) || (state_nxt == S_WAIT);
    stb_nxt  = (state_nxt == S_REQ);
    bwe_nxt  = cyc_nxt & we_nxt;
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= S_IDLE;
      to_cnt       <= 8'd0;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      off_q        <= 3'd0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      rwe_o        <= 1'b0;
      misaligned_o <= 1'b0;
      buserr_o     <= 1'b0;
      rd_o         <= 5'd0;
      rdat_o       <= 64'd0;
      wbm_cyc_o    <= 1'b0;
      wbm_stb_o    <= 1'b0;
      wbm_we_o     <= 1'b0;
      wbm_adr_o    <= 64'd0;
      wbm_sel_o    <= 8'd0;
      wbm_dat_o    <= 64'd0;
    end else begin
      state        <= state_nxt;
      to_cnt       <= to_cnt_nxt;
      we_q         <= we_nxt;
      size_q       <= size_nxt;
      uns_q        <= uns_nxt;
      off_q        <= off_nxt;
      busy_o       <= busy_nxt;
      done_o       <= done_nxt;
      rwe_o        <= rwe_nxt;
      misaligned_o <= mis_nxt;
      buserr_o     <= berr_nxt;
      rd_o         <= rd_nxt;
      rdat_o       <= rdat_nxt;
      wbm_cyc_o    <= cyc_nxt;
      wbm_stb_o    <= stb_nxt;
      wbm_we_o     <= bwe_nxt;
      wbm_adr_o    <= adr_nxt;
      wbm_sel_o    <= sel_nxt;
      wbm_dat_o    <= wdat_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_seq
// Purpose  : Self-checking bench for lsu_seq with a small Wishbone slave
//            model and a scoreboard of expected completions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_seq;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [1:0]  size_i = 2'd0;
  logic        unsigned_i = 1'b0;
  logic [63:0] addr_i = 64'd0;
  logic [63:0] dat_i = 64'd0;
  logic [4:0]  rd_i = 5'd0;
  logic        busy_o, done_o, rwe_o, misaligned_o, buserr_o;
  logic [4:0]  rd_o;
  logic [63:0] rdat_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [63:0] wbm_adr_o, wbm_dat_o;
  logic [7:0]  wbm_sel_o;
  logic [63:0] wbm_dat_i = 64'd0;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;
  logic        wbm_stall_i = 1'b0;

  lsu_seq #(.TIMEOUT(8)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .we_i(we_i),
    .size_i(size_i), .unsigned_i(unsigned_i), .addr_i(addr_i), .dat_i(dat_i),
    .rd_i(rd_i), .busy_o(busy_o), .done_o(done_o), .rwe_o(rwe_o),
    .rd_o(rd_o), .rdat_o(rdat_o), .misaligned_o(misaligned_o),
    .buserr_o(buserr_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_we_o(wbm_we_o), .wbm_adr_o(wbm_adr_o), .wbm_sel_o(wbm_sel_o),
    .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .wbm_err_i(wbm_err_i), .wbm_stall_i(wbm_stall_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] rdat;
    logic        rwe;
    logic        mis;
    logic        berr;
    logic [4:0]  rd;
  } result_t;

  result_t     exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] last_rdat = 64'd0;

  // Slave model: 0 = ack, 1 = err, 2 = never respond.
  int slave_mode = 0;
  int stall_cfg  = 0;
  int stall_cnt  = 0;
  bit resp_pending = 1'b0;

  always @(negedge clk or posedge reset_i) begin
    if (reset_i) begin
      wbm_ack_i    = 1'b0;
      wbm_err_i    = 1'b0;
      wbm_stall_i  = 1'b0;
      resp_pending = 1'b0;
      stall_cnt    = 0;
    end else begin
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      if (resp_pending) begin
        if (slave_mode == 1) wbm_err_i = 1'b1;
        else                 wbm_ack_i = 1'b1;
        resp_pending = 1'b0;
      end
      if (wbm_stb_o) begin
        if (stall_cnt > 0) begin
          wbm_stall_i = 1'b1;
          stall_cnt--;
        end else begin
          wbm_stall_i = 1'b0;
          if (slave_mode != 2) resp_pending = 1'b1;
        end
      end else begin
        wbm_stall_i = 1'b0;
        stall_cnt   = stall_cfg;
      end
    end
  end

  // Presents a request for one edge, then scrambles the request inputs so
  // any late sampling inside the DUT would show up as wrong results.
  task automatic issue_req(input logic we, input logic [1:0] size,
                           input logic uns, input logic [63:0] addr,
                           input logic [63:0] dat, input logic [4:0] rd);
    @(negedge clk);
    req_i = 1'b1; we_i = we; size_i = size; unsigned_i = uns;
    addr_i = addr; dat_i = dat; rd_i = rd;
    @(posedge clk);
    #1;
    req_i      = 1'b0;
    we_i       = 1'($urandom);
    size_i     = 2'($urandom);
    unsigned_i = 1'($urandom);
    addr_i     = {$urandom, $urandom};
    dat_i      = {$urandom, $urandom};
    rd_i       = 5'($urandom);
  endtask

  task automatic wait_done(output int cycles, output bit timed_out);
    cycles = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (done_o === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if ({busy_o, done_o, rwe_o, misaligned_o, buserr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 8'h00)
      $display("FAIL reset_ctrl: got %b want 00000000",
               {busy_o, done_o, rwe_o, misaligned_o, buserr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o});
    else n_pass++;
    n_checks++;
    if ({rd_o, rdat_o, wbm_adr_o, wbm_sel_o, wbm_dat_o} !== '0)
      $display("FAIL reset_data: rd=%h rdat=%h adr=%h sel=%h dat=%h want all 0",
               rd_o, rdat_o, wbm_adr_o, wbm_sel_o, wbm_dat_o);
    else n_pass++;
  endtask

  task automatic test_load_byte(input logic uns, input logic [63:0] want);
    int cyc_n; bit to; result_t obs, ex;
    slave_mode = 0; stall_cfg = 0;
    wbm_dat_i = 64'h0000_80FF_0000_0000;
    exp_q.push_back('{rdat: want, rwe: 1'b1, mis: 1'b0, berr: 1'b0, rd: 5'd7});
    last_rdat = want;
    issue_req(1'b0, 2'd0, uns, 64'h1005, 64'h0, 5'd7);
    n_checks++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o, wbm_sel_o, wbm_adr_o} !== {4'b1101, 8'h20, 64'h1000})
      $display("FAIL load_byte_bus: cyc/stb/we/busy=%b sel=%h adr=%h want 1101 20 1000",
               {wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o}, wbm_sel_o, wbm_adr_o);
    else n_pass++;
    wait_done(cyc_n, to);
    n_checks++;
    if (to || cyc_n != 2)
      $display("FAIL load_byte_latency: got %0d cycles (timeout=%0d) want 2", cyc_n, to);
    else n_pass++;
    ex  = exp_q.pop_front();
    obs = '{rdat: rdat_o, rwe: rwe_o, mis: misaligned_o, berr: buserr_o, rd: rd_o};
    n_checks++;
    if (obs !== ex) $display("FAIL load_byte_result: got %h want %h", obs, ex);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if ({done_o, busy_o, wbm_cyc_o} !== 3'b000)
      $display("FAIL load_byte_release: done/busy/cyc=%b want 000", {done_o, busy_o, wbm_cyc_o});
    else n_pass++;
  endtask

  task automatic test_store_half();
    int cyc_n, stb_n; bit to; result_t obs, ex;
    slave_mode = 0; stall_cfg = 3;
    exp_q.push_back('{rdat: last_rdat, rwe: 1'b0, mis: 1'b0, berr: 1'b0, rd: 5'd12});
    issue_req(1'b1, 2'd1, 1'b0, 64'h2006, 64'h0000_0000_0000_BEEF, 5'd12);
    n_checks++;
    if ({wbm_we_o, wbm_sel_o, wbm_dat_o} !== {1'b1, 8'hC0, 64'hBEEF_0000_0000_0000})
      $display("FAIL store_bus: we=%b sel=%h dat=%h want 1 c0 beef000000000000",
               wbm_we_o, wbm_sel_o, wbm_dat_o);
    else n_pass++;
    stb_n = 0;
    while (wbm_stb_o === 1'b1 && stb_n < 40) begin
      stb_n++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (stb_n != 4) $display("FAIL store_stb_len: got %0d want 4", stb_n);
    else n_pass++;
    wait_done(cyc_n, to);
    ex  = exp_q.pop_front();
    obs = '{rdat: rdat_o, rwe: rwe_o, mis: misaligned_o, berr: buserr_o, rd: rd_o};
    n_checks++;
    if (to || obs !== ex) $display("FAIL store_result: got %h want %h (timeout=%0d)", obs, ex, to);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_misaligned();
    result_t obs, ex;
    slave_mode = 0; stall_cfg = 0;
    exp_q.push_back('{rdat: last_rdat, rwe: 1'b0, mis: 1'b1, berr: 1'b0, rd: 5'd9});
    issue_req(1'b0, 2'd2, 1'b0, 64'h3002, 64'h0, 5'd9);
    n_checks++;
    if ({done_o, busy_o, wbm_cyc_o, wbm_stb_o} !== 4'b1100)
      $display("FAIL misaligned_timing: done/busy/cyc/stb=%b want 1100",
               {done_o, busy_o, wbm_cyc_o, wbm_stb_o});
    else n_pass++;
    ex  = exp_q.pop_front();
    obs = '{rdat: rdat_o, rwe: rwe_o, mis: misaligned_o, berr: buserr_o, rd: rd_o};
    n_checks++;
    if (obs !== ex) $display("FAIL misaligned_result: got %h want %h", obs, ex);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if ({done_o, busy_o, wbm_cyc_o} !== 3'b000)
      $display("FAIL misaligned_release: done/busy/cyc=%b want 000", {done_o, busy_o, wbm_cyc_o});
    else n_pass++;
  endtask

  task automatic test_buserr();
    int cyc_n; bit to; result_t obs, ex;
    slave_mode = 1; stall_cfg = 0;
    wbm_dat_i = 64'h1111_2222_3333_4444;
    exp_q.push_back('{rdat: last_rdat, rwe: 1'b0, mis: 1'b0, berr: 1'b1, rd: 5'd3});
    issue_req(1'b0, 2'd3, 1'b0, 64'h4000, 64'h0, 5'd3);
    wait_done(cyc_n, to);
    ex  = exp_q.pop_front();
    obs = '{rdat: rdat_o, rwe: rwe_o, mis: misaligned_o, berr: buserr_o, rd: rd_o};
    n_checks++;
    if (to || cyc_n != 2 || obs !== ex)
      $display("FAIL buserr_result: got %h after %0d cycles want %h after 2", obs, cyc_n, ex);
    else n_pass++;
    @(posedge clk);
    #1;
    slave_mode = 0;
  endtask

  task automatic test_load_patterns();
    logic [1:0]  p_size [5] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd0};
    logic        p_uns  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [63:0] p_addr [5] = '{64'h6006, 64'h6004, 64'h6004, 64'h6000, 64'h6003};
    logic [63:0] p_rdat [5] = '{64'h8001_0000_0000_0000, 64'hDEAD_BEEF_1234_5678,
                                64'hDEAD_BEEF_1234_5678, 64'h0123_4567_89AB_CDEF,
                                64'h0000_0000_7F00_0000};
    logic [63:0] p_want [5] = '{64'hFFFF_FFFF_FFFF_8001, 64'h0000_0000_DEAD_BEEF,
                                64'hFFFF_FFFF_DEAD_BEEF, 64'h0123_4567_89AB_CDEF,
                                64'h0000_0000_0000_007F};
    logic [7:0]  p_sel  [5] = '{8'hC0, 8'hF0, 8'hF0, 8'hFF, 8'h08};
    int cyc_n; bit to; result_t obs, ex;
    slave_mode = 0; stall_cfg = 0;
    for (int i = 0; i < 5; i++) begin
      wbm_dat_i = p_rdat[i];
      exp_q.push_back('{rdat: p_want[i], rwe: 1'b1, mis: 1'b0, berr: 1'b0, rd: 5'(i + 16)});
      last_rdat = p_want[i];
      issue_req(1'b0, p_size[i], p_uns[i], p_addr[i], 64'h0, 5'(i + 16));
      n_checks++;
      if ({wbm_sel_o, wbm_adr_o} !== {p_sel[i], 64'h6000})
        $display("FAIL pattern%0d_bus: sel=%h adr=%h want %h 6000", i, wbm_sel_o, wbm_adr_o, p_sel[i]);
      else n_pass++;
      wait_done(cyc_n, to);
      ex  = exp_q.pop_front();
      obs = '{rdat: rdat_o, rwe: rwe_o, mis: misaligned_o, berr: buserr_o, rd: rd_o};
      n_checks++;
      if (to || cyc_n != 2 || obs !== ex)
        $display("FAIL pattern%0d_result: got %h after %0d cycles want %h after 2", i, obs, cyc_n, ex);
      else n_pass++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_timeout();
    int cyc_cnt; result_t obs, ex;
    slave_mode = 2; stall_cfg = 0;
    exp_q.push_back('{rdat: last_rdat, rwe: 1'b0, mis: 1'b0, berr: 1'b1, rd: 5'd4});
    issue_req(1'b0, 2'd3, 1'b0, 64'h5000, 64'h0, 5'd4);
    cyc_cnt = 0;
    while (wbm_cyc_o === 1'b1 && cyc_cnt < 40) begin
      cyc_cnt++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (cyc_cnt != 8 || done_o !== 1'b1)
      $display("FAIL timeout_len: cyc high %0d cycles done=%b want 8 and done=1", cyc_cnt, done_o);
    else n_pass++;
    ex  = exp_q.pop_front();
    obs = '{rdat: rdat_o, rwe: rwe_o, mis: misaligned_o, berr: buserr_o, rd: rd_o};
    n_checks++;
    if (obs !== ex) $display("FAIL timeout_result: got %h want %h", obs, ex);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int done_seen;
    slave_mode = 2; stall_cfg = 0;
    issue_req(1'b0, 2'd3, 1'b0, 64'h7000, 64'h0, 5'd5);
    @(posedge clk);
    #1;
    n_checks++;
    if ({wbm_cyc_o, wbm_stb_o, busy_o} !== 3'b101)
      $display("FAIL reset_mid_wait: cyc/stb/busy=%b want 101", {wbm_cyc_o, wbm_stb_o, busy_o});
    else n_pass++;
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    n_checks++;
    if ({wbm_cyc_o, wbm_stb_o, busy_o} !== 3'b000)
      $display("FAIL reset_mid_async: cyc/stb/busy=%b want 000", {wbm_cyc_o, wbm_stb_o, busy_o});
    else n_pass++;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done_o === 1'b1) done_seen++;
    end
    n_checks++;
    if (done_seen != 0 || wbm_cyc_o !== 1'b0)
      $display("FAIL reset_mid_nodone: done pulses %0d cyc=%b want 0 and 0", done_seen, wbm_cyc_o);
    else n_pass++;
    slave_mode = 0;
  endtask

  initial begin
    test_reset();
    test_load_byte(1'b0, 64'hFFFF_FFFF_FFFF_FF80);
    test_load_byte(1'b1, 64'h0000_0000_0000_0080);
    test_store_half();
    test_misaligned();
    test_buserr();
    test_load_patterns();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
